tagged_branch_predictor: RTL and testbench

Parametrised, tagged, direct-mapped branch target buffer with per-entry saturating direction counters and statistics counters. It is the next-generation replacement for the untagged 256-entry target table in the pipelined TSC datapath. IF performs a combinational lookup on the fetch PC to obtain the predicted next PC. EX writes back the resolved outcome of each control instruction through the update port.

---
 rtl/tagged_branch_predictor_pkg.sv | 32 +++
 rtl/tagged_branch_predictor_sat_counter.sv | 28 ++
 rtl/tagged_branch_predictor.sv | 100 ++++++++++
 tb/tb_tagged_branch_predictor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tagged_branch_predictor_pkg.sv
// Shared constants and helpers for the tagged branch predictor: default widths,
// saturating-counter encoding and PC index/tag extraction.
package tagged_branch_predictor_pkg;

  localparam int unsigned DefaultWordSize = 16;
  localparam logic [31:0] SatMin          = 32'd0;

  // All-ones value of a counter of the given width.
  function automatic logic [31:0] sat_max(input int unsigned width);
    return (width >= 32) ? '1 : (32'd1 << width) - 32'd1;
  endfunction

  // Weakly-taken initial value: only the MSB set.
  function automatic logic [31:0] weak_taken(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic logic [31:0] sat_next(input logic [31:0] val, input logic up,
                                           input int unsigned width);
    if (up) return (val == sat_max(width)) ? val : val + 32'd1;
    return (val == SatMin) ? val : val - 32'd1;
  endfunction

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned index_bits);
    return pc & sat_max(index_bits);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned index_bits);
    return pc >> index_bits;
  endfunction

endpackage

// File: rtl/tagged_branch_predictor_sat_counter.sv
// Saturating up/down event counter; used for the predictor statistics.
module btb_sat_counter
  import tagged_branch_predictor_pkg::*;
#(
  parameter int unsigned Width   = 16,
  parameter bit          CountUp = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = Width'(sat_next(32'(count_q), CountUp, Width));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/tagged_branch_predictor.sv
// Tagged direct-mapped branch target buffer with saturating direction counters,
// combinational lookup and single-cycle update port.
module tagged_branch_predictor
  import tagged_branch_predictor_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = DefaultWordSize,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned STAT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 lookup_valid,
  input  logic [WORD_SIZE-1:0] lookup_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_next_pc,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_mispredict,
  output logic [STAT_BITS-1:0] stat_hits,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int unsigned Entries = 1 << INDEX_BITS;
  localparam int unsigned TagBits = WORD_SIZE - INDEX_BITS;

  logic [Entries-1:0]   valid_q;
  logic [TagBits-1:0]   tag_q    [Entries];
  logic [WORD_SIZE-1:0] target_q [Entries];
  logic [CTR_BITS-1:0]  ctr_q    [Entries];

  logic [INDEX_BITS-1:0] l_idx, u_idx;
  logic [TagBits-1:0]    l_tag, u_tag;
  logic                  u_hit;
  logic                  u_fire;
  logic [CTR_BITS-1:0]   ctr_next;

  assign l_idx = INDEX_BITS'(pc_index(32'(lookup_pc), INDEX_BITS));
  assign l_tag = TagBits'(pc_tag(32'(lookup_pc), INDEX_BITS));
  assign u_idx = INDEX_BITS'(pc_index(32'(upd_pc), INDEX_BITS));
  assign u_tag = TagBits'(pc_tag(32'(upd_pc), INDEX_BITS));

  // Lookup reads the registered array only, so a same-cycle update is not bypassed.
  assign pred_hit     = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken   = pred_hit && ctr_q[l_idx][CTR_BITS-1];
  assign pred_next_pc = pred_taken ? target_q[l_idx] : lookup_pc + WORD_SIZE'(1);

  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_fire   = upd_valid && !flush;
  assign ctr_next = CTR_BITS'(sat_next(32'(ctr_q[u_idx]), upd_taken, CTR_BITS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (u_fire && !u_hit && upd_taken) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (u_fire) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_next;
        if (upd_taken) target_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= CTR_BITS'(weak_taken(CTR_BITS));
      end
    end
  end

  btb_sat_counter #(
    .Width   (STAT_BITS),
    .CountUp (1'b1)
  ) u_stat_hits (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (lookup_valid && pred_hit),
    .count   (stat_hits)
  );

  btb_sat_counter #(
    .Width   (STAT_BITS),
    .CountUp (1'b1)
  ) u_stat_mispredicts (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (upd_valid && upd_mispredict),
    .count   (stat_mispredicts)
  );

endmodule

// File: tb/tb_tagged_branch_predictor.sv
// Self-checking bench: directed scenarios then random traffic against a table model.
module tb_tagged_branch_predictor;

  localparam int WS       = 16;
  localparam int IB       = 6;
  localparam int CB       = 2;
  localparam int SB       = 8;
  localparam int ENTRIES  = 64;
  localparam int CTR_MAX  = 3;
  localparam int STAT_MAX = 255;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          lookup_valid = 1'b0;
  logic [WS-1:0] lookup_pc = '0;
  logic          pred_hit, pred_taken;
  logic [WS-1:0] pred_next_pc;
  logic          upd_valid = 1'b0;
  logic [WS-1:0] upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic [WS-1:0] upd_target = '0;
  logic          upd_mispredict = 1'b0;
  logic [SB-1:0] stat_hits, stat_mispredicts;

  always #5 clk = ~clk;

  tagged_branch_predictor #(
    .WORD_SIZE  (WS),
    .INDEX_BITS (IB),
    .CTR_BITS   (CB),
    .STAT_BITS  (SB)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush            (flush),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_next_pc     (pred_next_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
  );

  int total = 0;
  int bad   = 0;

  // Reference table: one record per index, counters kept as plain integers.
  bit m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_ctr   [ENTRIES];
  int m_hits, m_mis;

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_mis  = 0;
  endfunction

  function automatic bit m_hit(input int pc);
    return m_valid[pc % ENTRIES] && (m_tag[pc % ENTRIES] == pc / ENTRIES);
  endfunction

  function automatic bit m_taken(input int pc);
    return m_hit(pc) && (m_ctr[pc % ENTRIES] >= 2);
  endfunction

  function automatic int m_next(input int pc);
    return m_taken(pc) ? m_tgt[pc % ENTRIES] : (pc + 1) % 65536;
  endfunction

  function automatic void m_update();
    int pc, idx;
    if (lookup_valid && m_hit(int'(lookup_pc))) m_hits = (m_hits < STAT_MAX) ? m_hits + 1 : STAT_MAX;
    if (upd_valid && upd_mispredict) m_mis = (m_mis < STAT_MAX) ? m_mis + 1 : STAT_MAX;
    pc  = int'(upd_pc);
    idx = pc % ENTRIES;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (upd_valid) begin
      if (m_hit(pc)) begin
        if (upd_taken) begin
          m_ctr[idx] = (m_ctr[idx] < CTR_MAX) ? m_ctr[idx] + 1 : CTR_MAX;
          m_tgt[idx] = int'(upd_target);
        end else begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = pc / ENTRIES;
        m_tgt[idx]   = int'(upd_target);
        m_ctr[idx]   = 2;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_lookup();
    check("pred_hit", 32'(pred_hit), 32'(m_hit(int'(lookup_pc))));
    check("pred_taken", 32'(pred_taken), 32'(m_taken(int'(lookup_pc))));
    check("pred_next_pc", 32'(pred_next_pc), 32'(m_next(int'(lookup_pc))));
  endtask

  task automatic check_stats();
    check("stat_hits", 32'(stat_hits), 32'(m_hits));
    check("stat_mispredicts", 32'(stat_mispredicts), 32'(m_mis));
  endtask

  // Called 1 time unit after a posedge; inputs settle, outputs sampled mid-cycle.
  task automatic step(input bit lv, input int lpc, input bit uv, input int upc, input bit ut,
                      input int utgt, input bit um, input bit fl);
    lookup_valid   = lv;
    lookup_pc      = WS'(lpc);
    upd_valid      = uv;
    upd_pc         = WS'(upc);
    upd_taken      = ut;
    upd_target     = WS'(utgt);
    upd_mispredict = um;
    flush          = fl;
    #3;
    check_lookup();
    m_update();
    @(posedge clk);
    #1;
    check_stats();
  endtask

  initial begin
    int lpc, upc;
    m_reset();
    lookup_pc = 16'h0012;
    #2;
    check_lookup();
    check_stats();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    step(1, 'h0012, 0, 0, 0, 0, 0, 0);
    // Update and lookup of the same PC: lookup sees the pre-update miss.
    step(1, 'h0012, 1, 'h0012, 1, 'h0040, 0, 0);
    step(1, 'h0012, 0, 0, 0, 0, 0, 0);
    // Alias at the same index with a different tag.
    step(1, 'h0052, 0, 0, 0, 0, 0, 0);
    step(1, 'h0052, 1, 'h0052, 1, 'h0070, 1, 0);
    step(1, 'h0012, 0, 0, 0, 0, 0, 0);
    step(1, 'h0052, 0, 0, 0, 0, 0, 0);
    // Counter walk down to saturation at zero, then back up to all-ones.
    for (int i = 0; i < 3; i++) step(1, 'h0052, 1, 'h0052, 0, 'h0999, 0, 0);
    step(1, 'h0052, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 'h0052, 1, 'h0052, 1, 'h0070 + i, 0, 0);
    step(1, 'h0052, 1, 'h0052, 0, 0, 0, 0);
    step(1, 'h0052, 0, 0, 0, 0, 0, 0);
    // Flush overrides a same-cycle allocation.
    step(0, 'h0012, 1, 'h0012, 1, 'h0040, 0, 1);
    step(1, 'h0052, 0, 0, 0, 0, 0, 0);
    step(1, 'h0012, 0, 0, 0, 0, 0, 0);
    step(1, 'h0012, 1, 'h0012, 1, 'h0040, 0, 0);
    step(1, 'h0012, 0, 0, 0, 0, 0, 0);
    // Mispredict statistic needs both upd_valid and upd_mispredict.
    step(0, 'h0012, 0, 'h0012, 0, 0, 1, 0);
    step(0, 'h0012, 1, 'h0300, 0, 0, 1, 0);
    step(1, 'hFFFF, 0, 0, 0, 0, 0, 0);

    // Drive stat_hits to all-ones minus one, then two more hits must hold all-ones.
    for (int i = 0; i < 300 && m_hits < STAT_MAX - 1; i++) step(1, 'h0012, 0, 0, 0, 0, 0, 0);
    step(1, 'h0012, 0, 0, 0, 0, 0, 0);
    step(1, 'h0012, 0, 0, 0, 0, 0, 0);
    check("stat_hits_saturated", 32'(stat_hits), 32'(STAT_MAX));

    // Asynchronous reset in the middle of a cycle carrying an update.
    lookup_valid = 1'b1;
    lookup_pc    = 16'h0012;
    upd_valid    = 1'b1;
    upd_pc       = 16'h0012;
    upd_taken    = 1'b1;
    upd_target   = 16'h0099;
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    check_lookup();
    check_stats();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1, 'h0012, 0, 0, 0, 0, 0, 0);
    step(1, 'h0052, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 500; n++) begin
      lpc = ($urandom_range(0, 15) == 0) ? 'hFFFF
                                         : int'($urandom_range(0, 3)) * 64 + int'($urandom_range(0, 7));
      upc = int'($urandom_range(0, 3)) * 64 + int'($urandom_range(0, 7));
      step(bit'($urandom_range(0, 1)), lpc, bit'($urandom_range(0, 1)), upc,
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
